// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl
// Operand-issue / result-capture stage for the 32x32 signed Booth multiplier.
// A request accepted on in_valid/in_ready drives the multiplier operand
// registers and gets a single-cycle start pulse. The block then waits for
// done, returns the selected half of the 64-bit product plus an overflow flag,
// and holds the response until the consumer takes it. A watchdog bounds the
// wait so that a multiplier that never finishes cannot hang the datapath.
//
// Optional feature macro: MUL_ZERO_BYPASS_EN
//   When defined, a request with a zero operand skips the multiplier and is
//   answered with a zero product on the cycle after acceptance.
module mult_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_ovf,
    output logic        out_err,
    output logic [31:0] mul_M,
    output logic [31:0] mul_Q,
    output logic        mul_start,
    input  logic [63:0] mul_result,
    input  logic        mul_done
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [WD_W-1:0] WD_ZERO = {WD_W{1'b0}};
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
    // Last WAIT cycle the watchdog allows; reaching it without done aborts.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic            op_r;
    logic            op_nxt_s;
    logic [WD_W-1:0] wd_r;
    logic [WD_W-1:0] wd_nxt_s;
    logic [31:0]     mul_m_nxt_s;
    logic [31:0]     mul_q_nxt_s;
    logic            start_nxt_s;
    logic            out_valid_nxt_s;
    logic [31:0]     out_data_nxt_s;
    logic            out_ovf_nxt_s;
    logic            out_err_nxt_s;
    logic            zero_req_s;

    // Low word overflows when the high word is not the sign extension of bit 31.
    function automatic logic low_word_ovf(input logic [63:0] p);
        return (p[63:32] != {32{p[31]}});
    endfunction

    // Word requested by the op code: 0 = low word (MUL), 1 = high word (MULH).
    function automatic logic [31:0] select_word(input logic [63:0] p, input logic high);
        logic [31:0] w;
        if (high) begin
            w = p[63:32];
        end else begin
            w = p[31:0];
        end
        return w;
    endfunction

    // Overflow is only meaningful for the low-word result.
    function automatic logic select_ovf(input logic [63:0] p, input logic high);
        logic f;
        if (high) begin
            f = 1'b0;
        end else begin
            f = low_word_ovf(p);
        end
        return f;
    endfunction

`ifdef MUL_ZERO_BYPASS_EN
    assign zero_req_s = (in_a == 32'd0) || (in_b == 32'd0);
`else
    assign zero_req_s = 1'b0;
`endif

    assign in_ready = (state_r == ST_IDLE);

    // Next-state and next-register values for the issue/wait/respond sequence.
    always_comb begin
        state_nxt_s     = state_r;
        op_nxt_s        = op_r;
        wd_nxt_s        = wd_r;
        mul_m_nxt_s     = mul_M;
        mul_q_nxt_s     = mul_Q;
        start_nxt_s     = 1'b0;
        out_valid_nxt_s = out_valid;
        out_data_nxt_s  = out_data;
        out_ovf_nxt_s   = out_ovf;
        out_err_nxt_s   = out_err;

        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    mul_m_nxt_s = in_a;
                    mul_q_nxt_s = in_b;
                    op_nxt_s    = in_op;
                    if (zero_req_s) begin
                        // Product is known to be zero; answer without the multiplier.
                        state_nxt_s     = ST_RESP;
                        out_valid_nxt_s = 1'b1;
                        out_data_nxt_s  = 32'd0;
                        out_ovf_nxt_s   = 1'b0;
                        out_err_nxt_s   = 1'b0;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                        start_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                // done may still be high from the previous op; it is not looked at here.
                wd_nxt_s    = WD_ZERO;
                state_nxt_s = ST_WAIT;
            end

            ST_WAIT: begin
                // wd_r == 0 marks the first WAIT cycle, where done may not yet
                // reflect the clear caused by this op's start pulse.
                if ((wd_r != WD_ZERO) && mul_done) begin
                    state_nxt_s     = ST_RESP;
                    out_valid_nxt_s = 1'b1;
                    out_data_nxt_s  = select_word(mul_result, op_r);
                    out_ovf_nxt_s   = select_ovf(mul_result, op_r);
                    out_err_nxt_s   = 1'b0;
                    wd_nxt_s        = wd_r + WD_ONE;
                end else if (wd_r == WD_LAST) begin
                    state_nxt_s     = ST_RESP;
                    out_valid_nxt_s = 1'b1;
                    out_data_nxt_s  = 32'd0;
                    out_ovf_nxt_s   = 1'b0;
                    out_err_nxt_s   = 1'b1;
                    wd_nxt_s        = wd_r + WD_ONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                    wd_nxt_s    = wd_r + WD_ONE;
                end
            end

            ST_RESP: begin
                if (out_ready) begin
                    out_valid_nxt_s = 1'b0;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end

            default: begin
                state_nxt_s     = ST_IDLE;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, operand, start and response registers; reset abandons any op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            op_r      <= 1'b0;
            wd_r      <= WD_ZERO;
            mul_M     <= 32'd0;
            mul_Q     <= 32'd0;
            mul_start <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_ovf   <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            op_r      <= op_nxt_s;
            wd_r      <= wd_nxt_s;
            mul_M     <= mul_m_nxt_s;
            mul_Q     <= mul_q_nxt_s;
            mul_start <= start_nxt_s;
            out_valid <= out_valid_nxt_s;
            out_data  <= out_data_nxt_s;
            out_ovf   <= out_ovf_nxt_s;
            out_err   <= out_err_nxt_s;
        end
    end

endmodule

// File: doc/mult_issue_ctrl.md
Name: mult_issue_ctrl

Overview:
Operand-issue and result-capture stage wrapped around the 32x32 signed Booth multiplier in the ALU datapath. It accepts a multiply request on a valid/ready handshake and holds the operands stable on the multiplier inputs. It pulses the multiplier start for one cycle, waits for done, and returns the selected 32-bit half of the 64-bit product with an overflow flag. A watchdog covers a multiplier that never completes.

Parameters:
TIMEOUT_CYCLES, 128, max WAIT cycles before aborting (must exceed worst-case multiplier latency of about 98 cycles); counter width is $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  request valid
in_ready  out  1  ready for request; high only in IDLE
in_a  in  32  multiplicand, signed
in_b  in  32  multiplier, signed
in_op  in  1  0 = low word (MUL), 1 = high word (MULH)
out_valid  out  1  response valid
out_ready  in  1  consumer ready
out_data  out  32  selected product word
out_ovf  out  1  low-word result not representable in 32-bit signed
out_err  out  1  watchdog timeout; out_data = 0
mul_M  out  32  to multiplier M, registered
mul_Q  out  32  to multiplier Q, registered
mul_start  out  1  to multiplier start, registered, one-cycle pulse
mul_result  in  64  from multiplier result
mul_done  in  1  from multiplier done (sticky until next start)

Behaviour:
- Reset (async, rst=1) forces all of the following; a reset mid-operation abandons any in-flight multiply silently:
  - state = IDLE
  - mul_M = 0, mul_Q = 0, mul_start = 0
  - out_valid = 0, out_data = 0, out_ovf = 0, out_err = 0
  - op latch = 0, watchdog = 0
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch in_a→mul_M, in_b→mul_Q, in_op; go to ISSUE.
- ISSUE (exactly one cycle):
  - mul_start = 1; mul_done is ignored because it may be stale-high from the previous op.
  - Clear the watchdog; go to WAIT.
- WAIT:
  - mul_start = 0.
  - mul_done is ignored in the first WAIT cycle (guard for the multiplier's registered clear).
  - From the second WAIT cycle on, mul_done = 1 captures mul_result (a 64-bit product P) and goes to RESP:
    - in_op = 0: out_data = P[31:0]; out_ovf = (P[63:32] != {32{P[31]}}).
    - in_op = 1: out_data = P[63:32]; out_ovf = 0.
    - out_err = 0.
  - Watchdog increments each WAIT cycle. On reaching TIMEOUT_CYCLES without done: out_data = 0, out_ovf = 0, out_err = 1, go to RESP.
  - If done and timeout coincide, done wins (out_err = 0).
- RESP:
  - out_valid = 1; out_data, out_ovf and out_err are held stable while out_ready = 0.
  - On out_ready = 1: out_valid drops next cycle and the block returns to IDLE.
  - No bypass: the next request is accepted in IDLE, one cycle after the handshake.
- mul_M and mul_Q change only on IDLE acceptance and hold steady through WAIT and RESP.
- Throughput: one op in flight. Latency from in_valid to out_valid = 2 + multiplier latency.
- out_* are outputs of registers only; in_ready is decoded from state.

Optional Feature:
MUL_ZERO_BYPASS_EN
- Defined: in IDLE, an accepted request with in_a == 0 or in_b == 0 skips ISSUE and WAIT, issues no mul_start, and enters RESP next cycle with out_data = 0, out_ovf = 0, out_err = 0.
- Undefined: every request goes through the multiplier, zero operands included.

Test Plan:
- a=7, b=-3 (0xFFFFFFFD), op=0 → out_data=0xFFFFFFEB, ovf=0, err=0; mul_start high for exactly 1 cycle.
- a=b=0x80000000: op=1 → out_data=0x40000000, ovf=0; op=0 → out_data=0x00000000, ovf=1.
- Back-to-back ops with mul_done still high from the previous op → no early capture; second result correct (a=0x10000, b=0x10000, op=1 → 0x00000001).
- out_ready held low 5 cycles in RESP → out_valid, out_data and ovf stable; in_ready=0; one response only after out_ready rises.
- TIMEOUT_CYCLES=16 with mul_done tied 0 → out_valid with err=1, data=0 after 16 WAIT cycles; then a normal op succeeds once done is restored.
- rst pulsed mid-WAIT → all outputs 0 immediately, state IDLE, in_ready=1; next op (a=5, b=6, op=0) → 30. With MUL_ZERO_BYPASS_EN: a=0, b=9 → no mul_start, out_valid 1 cycle after acceptance, data=0.
